// File: rtl/rs_age_arbiter.sv
// rs_age_arbiter: age-ordered grant across reservation-station channels into a 2-entry output FIFO.
// Build option: define RS_ARB_STARVE_GUARD_EN to add per-channel starvation counters
// that override age order once a channel has waited STARVE_LIMIT cycles.
module rs_age_arbiter #(
    parameter int N_CH         = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 16,
    parameter int RS_ID_WIDTH  = 5,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_CH-1:0]                     in_valid,
    output logic [N_CH-1:0]                     in_ready,
    input  logic [N_CH-1:0][RS_ID_WIDTH-1:0]    in_rs_id,
    input  logic [N_CH-1:0][DATA_WIDTH-1:0]     in_data,
    input  logic [N_CH-1:0][CTRL_WIDTH-1:0]     in_ctrl,
    input  logic [RS_ID_WIDTH-1:0]              head_id,
    input  logic                                flush,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RS_ID_WIDTH-1:0]              out_rs_id,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [CTRL_WIDTH-1:0]               out_ctrl,
    output logic [$clog2(N_CH)-1:0]             out_ch
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int ENT_W = RS_ID_WIDTH + DATA_WIDTH + CTRL_WIDTH + CH_W;

    if (N_CH < 2 || N_CH > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("rs_age_arbiter: parameter out of range");
    end

    logic [N_CH-1:0][RS_ID_WIDTH-1:0] age;
    logic [N_CH-1:0]                  starved;
    logic                             gnt_any;
    logic [CH_W-1:0]                  gnt_idx;
    logic [RS_ID_WIDTH-1:0]           best_age;
    logic                             push;
    logic                             pop;
    logic [1:0]                       count;
    logic [ENT_W-1:0]                 entry;
    logic [ENT_W-1:0]                 slot0;
    logic [ENT_W-1:0]                 slot1;

    // Age is distance from the oldest in-flight ID, so wrap of the ID space is harmless.
    for (genvar g = 0; g < N_CH; g++) begin : g_age
        assign age[g] = in_rs_id[g] - head_id;
    end

`ifdef RS_ARB_STARVE_GUARD_EN
    logic [N_CH-1:0][7:0] starve_cnt;

    for (genvar g = 0; g < N_CH; g++) begin : g_starve
        assign starved[g] = in_valid[g] && starve_cnt[g] >= 8'(STARVE_LIMIT);
    end

    // Count cycles a valid channel is passed over; saturate at the limit, clear on accept or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                starve_cnt[i] <= (!in_valid[i] || in_ready[i]) ? 8'd0 :
                                 starve_cnt[i] + {7'd0, starve_cnt[i] < 8'(STARVE_LIMIT)};
        end
    end
`else
    assign starved = '0;
`endif

    // Oldest valid channel wins (lowest index on ties); a starved channel, lowest first, overrides age.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        best_age = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_valid[i] && (!gnt_any || age[i] < best_age)) begin
                gnt_any  = 1'b1;
                gnt_idx  = CH_W'(i);
                best_age = age[i];
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (starved[i]) gnt_idx = CH_W'(i);
        end
    end

    // Acceptance depends only on the registered count, keeping out_ready off the in_ready path.
    assign push      = rst && !flush && count != 2'd2 && gnt_any;
    assign in_ready  = push ? (N_CH'(1) << gnt_idx) : '0;
    assign entry     = {in_rs_id[gnt_idx], in_data[gnt_idx], in_ctrl[gnt_idx], gnt_idx};
    assign out_valid = count != 2'd0;
    assign pop       = out_valid && out_ready;
    assign {out_rs_id, out_data, out_ctrl, out_ch} = slot0;

    // Two-slot in-order FIFO: slot0 is always the head; flush wins over any pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (push && (count == 2'd0 || pop)) slot0 <= entry;
            else if (pop && count == 2'd2) slot0 <= slot1;
            if (push && !pop && count == 2'd1) slot1 <= entry;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_rs_age_arbiter.sv
// tb_rs_age_arbiter: randomized + directed scoreboard bench for rs_age_arbiter (3 channels, 5-bit IDs).
module tb_rs_age_arbiter;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] d;
        logic [15:0] c;
        logic [1:0]  ch;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [2:0]        in_valid = '0;
    logic [2:0]        in_ready;
    logic [2:0][4:0]   in_rs_id = '0;
    logic [2:0][31:0]  in_data = '0;
    logic [2:0][15:0]  in_ctrl = '0;
    logic [4:0]        head_id = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [4:0]        out_rs_id;
    logic [31:0]       out_data;
    logic [15:0]       out_ctrl;
    logic [1:0]        out_ch;

    ent_t q[$];
    int   scnt[3];
    int   n_tests = 0;
    int   n_fail = 0;

    rs_age_arbiter #(
        .N_CH(3), .DATA_WIDTH(32), .CTRL_WIDTH(16), .RS_ID_WIDTH(5), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs_id(in_rs_id),
        .in_data(in_data), .in_ctrl(in_ctrl), .head_id(head_id), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs_id(out_rs_id),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: sort key is age*8+index; a starved channel jumps ahead of every age.
    function automatic int model_grant();
        int best = -1;
        int best_key = 0;
        int key;
        for (int i = 0; i < 3; i++) begin
            if (in_valid[i]) begin
                key = ((int'(in_rs_id[i]) - int'(head_id) + 32) % 32) * 8 + i;
`ifdef RS_ARB_STARVE_GUARD_EN
                if (scnt[i] >= LIMIT) key = i - 8;
`endif
                if (best < 0 || key < best_key) begin
                    best = i;
                    best_key = key;
                end
            end
        end
        return best;
    endfunction

    // One cycle of stimulus: drive at negedge, check in_ready at +1, record acceptance at +3.
    task automatic step(input logic [2:0] v, input int i0, input int i1, input int i2,
                        input int hd, input logic ordy, input logic fl);
        int g;
        logic [2:0] exp_rdy;
        @(negedge clk);
        in_valid = v;
        in_rs_id[0] = 5'(i0);
        in_rs_id[1] = 5'(i1);
        in_rs_id[2] = 5'(i2);
        head_id = 5'(hd);
        out_ready = ordy;
        flush = fl;
        for (int c = 0; c < 3; c++) begin
            in_data[c] = $urandom;
            in_ctrl[c] = 16'($urandom);
        end
        #1;
        g = model_grant();
        exp_rdy = (g >= 0 && q.size() < 2 && !fl) ? 3'(1 << g) : 3'b000;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        #2;
        if (exp_rdy != 3'b000) q.push_back('{in_rs_id[g], in_data[g], in_ctrl[g], 2'(g)});
        for (int i = 0; i < 3; i++)
            scnt[i] = (!v[i] || exp_rdy[i]) ? 0 : (scnt[i] < LIMIT ? scnt[i] + 1 : scnt[i]);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_rs_id", 64'(out_rs_id), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        check("rst_out_ch", 64'(out_ch), 64'(0));
    endtask

    // Monitor: compares the presented head with the scoreboard, pops on handshake, clears on flush.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("out_valid", 64'(out_valid), 64'(q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    check("out_rs_id", 64'(out_rs_id), 64'(q[0].id));
                    check("out_data", 64'(out_data), 64'(q[0].d));
                    check("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
                    check("out_ch", 64'(out_ch), 64'(q[0].ch));
                end
                if (flush) q.delete();
                else if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) scnt[i] = 0;
        repeat (2) @(negedge clk);
        in_valid = 3'b111;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 3'b000;

        // Age order with head 0: ids 3, 5, 7 leave in that order, then an idle cycle.
        step(3'b111, 7, 3, 5, 0, 1'b1, 1'b0);
        step(3'b101, 7, 3, 5, 0, 1'b1, 1'b0);
        step(3'b001, 7, 3, 5, 0, 1'b1, 1'b0);
        step(3'b000, 7, 3, 5, 0, 1'b1, 1'b0);
        step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);

        // Head wrap: with head 30, id 31 is older than id 1.
        step(3'b011, 1, 31, 0, 30, 1'b1, 1'b0);
        step(3'b001, 1, 31, 0, 30, 1'b1, 1'b0);
        repeat (2) step(3'b000, 0, 0, 0, 30, 1'b1, 1'b0);

        // Backpressure: two accepted, third held until the first pop frees a slot.
        step(3'b111, 7, 3, 5, 0, 1'b0, 1'b0);
        step(3'b101, 7, 3, 5, 0, 1'b0, 1'b0);
        step(3'b001, 7, 3, 5, 0, 1'b0, 1'b0);
        step(3'b001, 7, 3, 5, 0, 1'b0, 1'b0);
        step(3'b001, 7, 3, 5, 0, 1'b1, 1'b0);
        step(3'b001, 7, 3, 5, 0, 1'b1, 1'b0);
        repeat (3) step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);

        // Flush with a full FIFO and out_ready high: nothing accepted or emitted.
        step(3'b111, 9, 4, 6, 0, 1'b0, 1'b0);
        step(3'b101, 9, 4, 6, 0, 1'b0, 1'b0);
        step(3'b111, 9, 4, 6, 0, 1'b1, 1'b1);
        step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);
        step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);

        // ch2 (id 20) competes against a stream of older ch0 entries.
        for (int k = 0; k < 6; k++) step(3'b101, k + 1, 0, 20, 0, 1'b1, 1'b0);
        repeat (3) step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);

        // Reset mid-transfer with two entries buffered.
        step(3'b111, 7, 3, 5, 0, 1'b0, 1'b0);
        step(3'b101, 7, 3, 5, 0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 3'b111;
        out_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        for (int i = 0; i < 3; i++) scnt[i] = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        step(3'b010, 0, 12, 0, 0, 1'b1, 1'b0);
        step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);

        // Random traffic: random valids, IDs, head, backpressure and occasional flush.
        repeat (400)
            step(3'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        repeat (3) step(3'b000, 0, 0, 0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
